// File: rtl/alu_decode_if.sv
// Handshake and decoded-field bundle between the fetch side, the decode stage and the regfile/ALU side.
// The decode stage is the slave; the producer/consumer pair driving it is the master.
interface alu_decode_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [3:0]  cond;
  logic        s_bit;
  logic        flag_en;
  logic [3:0]  rd;
  logic [3:0]  rn;
  logic [3:0]  rm;
  logic [2:0]  sr_cont;
  logic [4:0]  sr_bit;
  logic [15:0] immediate;
  logic        uses_rn;
  logic        uses_rm;
  logic        wr_en;
  logic        illegal;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, opcode, cond, s_bit, flag_en, rd, rn, rm,
           sr_cont, sr_bit, immediate, uses_rn, uses_rm, wr_en, illegal
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, opcode, cond, s_bit, flag_en, rd, rn, rm,
           sr_cont, sr_bit, immediate, uses_rn, uses_rm, wr_en, illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// Decode stage ahead of the ALU: slices the instruction word into control fields, holds one
// decoded entry, stalls one cycle on a load-use dependency and counts issues and bubbles.
module alu_decode_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_decode_if.slave      bus,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned REG_W = 4;
  localparam logic [3:0]  OP_CMP  = 4'b1011;
  localparam logic [3:0]  OP_LOAD = 4'b1101;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [3:0]       cond;
    logic [3:0]       opcode;
    logic             s_bit;
    logic             flag_en;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [2:0]       sr_cont;
    logic [4:0]       sr_bit;
    logic [15:0]      immediate;
    logic             uses_rn;
    logic             uses_rm;
    logic             wr_en;
    logic             illegal;
  } dec_t;

  dec_t             in_dec_c;
  dec_t             held_q, held_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             hazard_c, ready_c, load_c, handoff_c;

  // Field slicing and opcode classification of the incoming word.
  always_comb begin
    in_dec_c           = '0;
    in_dec_c.cond      = bus.in_instr[31:28];
    in_dec_c.opcode    = bus.in_instr[27:24];
    in_dec_c.s_bit     = bus.in_instr[23];
    in_dec_c.rd        = bus.in_instr[22:19];
    in_dec_c.rn        = bus.in_instr[18:15];
    in_dec_c.rm        = bus.in_instr[14:11];
    in_dec_c.sr_cont   = bus.in_instr[10:8];
    in_dec_c.sr_bit    = bus.in_instr[7:3];
    in_dec_c.immediate = bus.in_instr[15:0];
    case (bus.in_instr[27:24])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        in_dec_c.uses_rn = 1'b1;
        in_dec_c.uses_rm = 1'b1;
        in_dec_c.wr_en   = 1'b1;
      end
      4'h6: in_dec_c.wr_en = 1'b1;
      4'h7, OP_LOAD: begin
        in_dec_c.uses_rn = 1'b1;
        in_dec_c.wr_en   = 1'b1;
      end
      OP_CMP: begin
        in_dec_c.uses_rn = 1'b1;
        in_dec_c.uses_rm = 1'b1;
      end
      4'hE: in_dec_c.uses_rn = 1'b1;
      default: in_dec_c.illegal = 1'b1;
    endcase
    in_dec_c.flag_en = !in_dec_c.illegal &&
                       (in_dec_c.s_bit || (in_dec_c.opcode == OP_CMP));
  end

  // Handshake, load-use hazard and next-state for the held entry and counters.
  always_comb begin
    hazard_c = out_valid_q && (held_q.opcode == OP_LOAD) && held_q.wr_en && bus.in_valid &&
               ((in_dec_c.uses_rn && (in_dec_c.rn == held_q.rd)) ||
                (in_dec_c.uses_rm && (in_dec_c.rm == held_q.rd)));
    ready_c   = !bus.flush && !hazard_c && (!out_valid_q || bus.out_ready);
    load_c    = bus.in_valid && ready_c;
    handoff_c = out_valid_q && bus.out_ready;

    held_d      = held_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (load_c) begin
      held_d      = in_dec_c;
      out_valid_d = 1'b1;
    end else if (handoff_c) begin
      out_valid_d = 1'b0;
    end

    issue_d = issue_q;
    if (handoff_c && (issue_q != CNT_MAX)) begin
      issue_d = issue_q + CNT_W'(1);
    end
    bubble_d = bubble_q;
    if (hazard_c && bus.out_ready && !bus.flush && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q      <= '0;
      out_valid_q <= 1'b0;
      issue_q     <= '0;
      bubble_q    <= '0;
    end else begin
      held_q      <= held_d;
      out_valid_q <= out_valid_d;
      issue_q     <= issue_d;
      bubble_q    <= bubble_d;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.cond      = held_q.cond;
  assign bus.opcode    = held_q.opcode;
  assign bus.s_bit     = held_q.s_bit;
  assign bus.flag_en   = held_q.flag_en;
  assign bus.rd        = held_q.rd;
  assign bus.rn        = held_q.rn;
  assign bus.rm        = held_q.rm;
  assign bus.sr_cont   = held_q.sr_cont;
  assign bus.sr_bit    = held_q.sr_bit;
  assign bus.immediate = held_q.immediate;
  assign bus.uses_rn   = held_q.uses_rn;
  assign bus.uses_rm   = held_q.uses_rm;
  assign bus.wr_en     = held_q.wr_en;
  assign bus.illegal   = held_q.illegal;
  assign issue_cnt     = issue_q;
  assign bubble_cnt    = bubble_q;

endmodule
